// File: rtl/approx_mul_ctrl.sv
// approx_mul_ctrl: sequential controller for a truncate-and-merge approximate
// multiplier. Each operand is normalised to its top KEEP significant bits.
// The two segments are multiplied with an iterative shift-add. The segment
// product is then shifted back to full 2*WIDTH scale by the total number of
// discarded bits. Only one operation is in flight at a time.
//
// Optional build macro: APPROX_MUL_ROUND_EN
//   When defined, each segment is rounded using the last bit shifted out
//   during normalisation, saturating at 2^KEEP-1. Latency does not change.
//   When undefined, discarded bits are truncated.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operands present
//   in_ready     controller idle and accepting (state == IDLE)
//   in_a, in_b   unsigned operands (WIDTH bits)
//   out_valid    result present (state == DONE)
//   out_ready    consumer accepts result
//   out_product  approximate product (2*WIDTH bits), held through DONE
//   out_shift    merge shift applied, sA+sB (SHW bits)
//   busy         high in any state except IDLE
module approx_mul_ctrl #(
    parameter int WIDTH = 16,
    parameter int KEEP  = 8,
    parameter int SHW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [SHW-1:0]     out_shift,
    output logic               busy
);

    localparam int CW = $clog2(KEEP + 1);

    typedef enum logic [2:0] {IDLE, ZERO, NORM, MUL, MERGE, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     ra_q, ra_d, rb_q, rb_d;
    logic [SHW-1:0]       sa_q, sa_d, sb_q, sb_d;
    logic [2*KEEP-1:0]    mcand_q, mcand_d;
    logic [KEEP-1:0]      mplr_q, mplr_d;
    logic [2*KEEP-1:0]    acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [SHW-1:0]       shift_q, shift_d;
`ifdef APPROX_MUL_ROUND_EN
    logic                 rba_q, rba_d, rbb_q, rbb_d;
`endif

    logic                 a_big, b_big;
    logic [KEEP-1:0]      seg_a, seg_b;
    logic [SHW-1:0]       shift_sum;
    logic [2*WIDTH-1:0]   prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            shift_q <= '0;
`ifdef APPROX_MUL_ROUND_EN
            rba_q   <= 1'b0;
            rbb_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            shift_q <= shift_d;
`ifdef APPROX_MUL_ROUND_EN
            rba_q   <= rba_d;
            rbb_q   <= rbb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        shift_d = shift_q;
`ifdef APPROX_MUL_ROUND_EN
        rba_d   = rba_q;
        rbb_d   = rbb_q;
`endif

        // An operand is still too wide while any bit at or above KEEP is set.
        a_big = (ra_q >> KEEP) != '0;
        b_big = (rb_q >> KEEP) != '0;

        seg_a = ra_q[KEEP-1:0];
        seg_b = rb_q[KEEP-1:0];
`ifdef APPROX_MUL_ROUND_EN
        if (rba_q && (seg_a != '1)) seg_a = seg_a + 1'b1;
        if (rbb_q && (seg_b != '1)) seg_b = seg_b + 1'b1;
`endif

        shift_sum = sa_q + sb_q;
        prod_ext  = '0;
        prod_ext[2*KEEP-1:0] = acc_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d  = in_a;
                    rb_d  = in_b;
                    sa_d  = '0;
                    sb_d  = '0;
                    acc_d = '0;
`ifdef APPROX_MUL_ROUND_EN
                    rba_d = 1'b0;
                    rbb_d = 1'b0;
`endif
                    state_d = ((in_a == '0) || (in_b == '0)) ? ZERO : NORM;
                end
            end
            // The zero path reuses MERGE, which produces 0 << 0 from the
            // cleared accumulator. This places the result two edges after
            // accept.
            ZERO: state_d = MERGE;
            NORM: begin
                if (a_big) begin
                    ra_d = ra_q >> 1;
                    sa_d = sa_q + 1'b1;
`ifdef APPROX_MUL_ROUND_EN
                    rba_d = ra_q[0];
`endif
                end
                if (b_big) begin
                    rb_d = rb_q >> 1;
                    sb_d = sb_q + 1'b1;
`ifdef APPROX_MUL_ROUND_EN
                    rbb_d = rb_q[0];
`endif
                end
                if (!a_big && !b_big) begin
                    mcand_d = '0;
                    mcand_d[KEEP-1:0] = seg_a;
                    mplr_d  = seg_b;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mplr_q[0]) acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(KEEP - 1)) state_d = MERGE;
            end
            MERGE: begin
                prod_d  = prod_ext << shift_sum;
                shift_d = shift_sum;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_product = prod_q;
    assign out_shift   = shift_q;

endmodule

// File: tb/tb_approx_mul_ctrl.sv
module tb_approx_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_product;
    logic [4:0]  out_shift;
    logic        busy;

    int checks = 0;
    int failures = 0;

    approx_mul_ctrl #(.WIDTH(16), .KEEP(8), .SHW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_shift(out_shift),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Present operands and return just after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid is seen (bounded at 100).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl got rdy/val/busy=%b want 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_product !== 32'd0 || out_shift !== 5'd0) begin
            failures++;
            $display("FAIL reset_data got prod=%h shift=%0d want 0/0", out_product, out_shift);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_small();
        int lat;
        start_op(16'd3, 16'd5);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("FAIL small_lat got %0d want 10", lat);
        end
        checks++;
        if (out_product !== 32'd15 || out_shift !== 5'd0) begin
            failures++;
            $display("FAIL small_res got prod=%h shift=%0d want 0000000f/0", out_product, out_shift);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL small_consume got val=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_norm_a();
        int lat;
        start_op(16'h1234, 16'h00FF);
        wait_valid(lat);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL norm_a_lat got %0d want 15", lat);
        end
        checks++;
        if (out_product !== 32'h00120DE0 || out_shift !== 5'd5) begin
            failures++;
            $display("FAIL norm_a_res got prod=%h shift=%0d want 00120de0/5", out_product, out_shift);
        end
        consume();
    endtask

    task automatic test_max();
        int lat;
        start_op(16'hFFFF, 16'hFFFF);
        wait_valid(lat);
        checks++;
        if (lat !== 18) begin
            failures++;
            $display("FAIL max_lat got %0d want 18", lat);
        end
        checks++;
        if (out_product !== 32'hFE010000 || out_shift !== 5'd16) begin
            failures++;
            $display("FAIL max_res got prod=%h shift=%0d want fe010000/16", out_product, out_shift);
        end
        consume();
    endtask

    task automatic test_zero();
        start_op(16'h0000, 16'hABCD);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_mid got busy=%b val=%b want 1/0", busy, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_edge1 got busy=%b val=%b want 1/0", busy, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_product !== 32'd0 || out_shift !== 5'd0) begin
            failures++;
            $display("FAIL zero_res got val=%b prod=%h shift=%0d want 1/0/0", out_valid, out_product, out_shift);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(16'd3, 16'd5);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("FAIL bp_lat got %0d want 10", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a = 16'h1111 * 16'(i + 1);
            in_b = 16'h0F0F ^ 16'(i);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_product !== 32'd15 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got val=%b prod=%h rdy=%b want 1/0000000f/0",
                         i, out_valid, out_product, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got val=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(16'hFFFF, 16'hFFFF);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_ctrl got rdy/val/busy=%b want 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_product !== 32'd0 || out_shift !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid_data got prod=%h shift=%0d want 0/0", out_product, out_shift);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(16'd2, 16'd2);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("FAIL after_rst_lat got %0d want 10", lat);
        end
        checks++;
        if (out_product !== 32'd4 || out_shift !== 5'd0) begin
            failures++;
            $display("FAIL after_rst_res got prod=%h shift=%0d want 00000004/0", out_product, out_shift);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_small();
        test_norm_a();
        test_max();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
